// File: rtl/pipe_reg_skid.sv
// Pipeline register stage with a 2-entry skid buffer, so in_ready comes straight from a flop.
// Optional saturating stall counter is enabled by defining PIPE_REG_STALL_CNT_EN.
module pipe_reg_skid #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int               STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
`ifdef PIPE_REG_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
    output logic [1:0]             occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   main_data_r, main_data_s;
    logic [WIDTH-1:0]   skid_data_r, skid_data_s;
    logic               out_valid_r, out_valid_s;
    logic               in_ready_r, in_ready_s;
    logic [1:0]         occupancy_r, occupancy_s;
    logic               in_xfer_s, out_xfer_s;

    // Next-state, next-data and next-output decode for the skid FSM
    always_comb begin
        state_s     = state_r;
        main_data_s = main_data_r;
        skid_data_s = skid_data_r;
        in_xfer_s   = in_valid && in_ready_r;
        out_xfer_s  = out_valid_r && out_ready;

        case (state_r)
            EMPTY: begin
                if (in_xfer_s) begin
                    main_data_s = in_data;
                    state_s     = HALF;
                end else begin
                    state_s     = EMPTY;
                end
            end
            HALF: begin
                if (in_xfer_s && out_xfer_s) begin
                    main_data_s = in_data;
                    state_s     = HALF;
                end else if (in_xfer_s) begin
                    skid_data_s = in_data;
                    state_s     = FULL;
                end else if (out_xfer_s) begin
                    state_s     = EMPTY;
                end else begin
                    state_s     = HALF;
                end
            end
            FULL: begin
                if (out_xfer_s) begin
                    main_data_s = skid_data_r;
                    state_s     = HALF;
                end else begin
                    state_s     = FULL;
                end
            end
            default: begin
                state_s = EMPTY;
            end
        endcase

        // Flush drops everything held or arriving, but leaves the data flops untouched
        if (flush) begin
            state_s     = EMPTY;
            main_data_s = main_data_r;
            skid_data_s = skid_data_r;
        end else begin
            state_s     = state_s;
        end

        case (state_s)
            EMPTY: begin
                out_valid_s = 1'b0;
                in_ready_s  = 1'b1;
                occupancy_s = 2'd0;
            end
            HALF: begin
                out_valid_s = 1'b1;
                in_ready_s  = 1'b1;
                occupancy_s = 2'd1;
            end
            FULL: begin
                out_valid_s = 1'b1;
                in_ready_s  = 1'b0;
                occupancy_s = 2'd2;
            end
            default: begin
                out_valid_s = 1'b0;
                in_ready_s  = 1'b1;
                occupancy_s = 2'd0;
            end
        endcase
    end

    // State, data and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= EMPTY;
            main_data_r <= RESET_VALUE;
            skid_data_r <= RESET_VALUE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occupancy_r <= 2'd0;
        end else begin
            state_r     <= state_s;
            main_data_r <= main_data_s;
            skid_data_r <= skid_data_s;
            out_valid_r <= out_valid_s;
            in_ready_r  <= in_ready_s;
            occupancy_r <= occupancy_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = main_data_r;
    assign in_ready  = in_ready_r;
    assign occupancy = occupancy_r;

`ifdef PIPE_REG_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    // Saturating count of cycles where a valid output is held off by the consumer
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (out_valid_r && !out_ready && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed self-checking bench for pipe_reg_skid; exercises the stall counter when
// PIPE_REG_STALL_CNT_EN is defined.
module tb_pipe_reg_skid;

    localparam int WIDTH       = 32;
    localparam int STALL_CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
`ifdef PIPE_REG_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;
`endif

    int n_compared;
    int n_mismatched;

    pipe_reg_skid #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ({WIDTH{1'b0}}),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef PIPE_REG_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        step();
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_occupancy", 64'(occupancy), 64'd0);
        check_val("rst_in_ready",  64'(in_ready),  64'd1);
        check_val("rst_out_data",  64'(out_data),  64'd0);

        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        check_val("idle_out_valid", 64'(out_valid), 64'd0);

        // Streaming at full throughput
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            step();
            check_val("stream_data",  64'(out_data),  64'(i));
            check_val("stream_valid", 64'(out_valid), 64'd1);
            check_val("stream_occ",   64'(occupancy), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check_val("stream_drain_valid", 64'(out_valid), 64'd0);

        // Back-pressure fills the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd5;
        step();
        check_val("bp_half_ready", 64'(in_ready),  64'd1);
        check_val("bp_half_occ",   64'(occupancy), 64'd1);
        in_data = 32'd6;
        step();
        check_val("bp_full_occ",   64'(occupancy), 64'd2);
        check_val("bp_full_ready", 64'(in_ready),  64'd0);
        check_val("bp_full_data",  64'(out_data),  64'd5);
        in_data = 32'd99;
        step();
        check_val("bp_hold_data", 64'(out_data),  64'd5);
        check_val("bp_hold_occ",  64'(occupancy), 64'd2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_val("bp_pop1_data",  64'(out_data),  64'd6);
        check_val("bp_pop1_ready", 64'(in_ready),  64'd1);
        check_val("bp_pop1_occ",   64'(occupancy), 64'd1);
        step();
        check_val("bp_pop2_valid", 64'(out_valid), 64'd0);

        // HALF with no traffic holds its entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd14;
        step();
        in_valid = 1'b0;
        step();
        check_val("half_hold_data", 64'(out_data),  64'd14);
        check_val("half_hold_occ",  64'(occupancy), 64'd1);

        // Flush from HALF drops the incoming transfer too
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd11;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("flush_half_occ", 64'(occupancy), 64'd0);
        check_val("flush_half_valid", 64'(out_valid), 64'd0);

        // Flush while FULL
        in_valid = 1'b1;
        in_data  = 32'd7;
        step();
        in_data = 32'd8;
        step();
        check_val("pre_flush_occ", 64'(occupancy), 64'd2);
        flush   = 1'b1;
        in_data = 32'd9;
        step();
        check_val("flush_full_occ",   64'(occupancy), 64'd0);
        check_val("flush_full_valid", 64'(out_valid), 64'd0);
        check_val("flush_full_ready", 64'(in_ready),  64'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_val("flush_no9_valid", 64'(out_valid), 64'd0);

        // Reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd12;
        step();
        in_data = 32'd13;
        step();
        check_val("pre_rst_occ", 64'(occupancy), 64'd2);
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        check_val("rst_full_occ",   64'(occupancy), 64'd0);
        check_val("rst_full_data",  64'(out_data),  64'd0);
        check_val("rst_full_ready", 64'(in_ready),  64'd1);
        reset = 1'b0;

`ifdef PIPE_REG_STALL_CNT_EN
        // Stall counter saturates, survives flush, clears on reset
        check_val("stall_after_rst", 64'(stall_cnt), 64'd0);
        in_valid = 1'b1;
        in_data  = 32'd21;
        step();
        in_valid = 1'b0;
        check_val("stall_first", 64'(stall_cnt), 64'd0);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check_val("stall_sat", 64'(stall_cnt), 64'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("stall_flush", 64'(stall_cnt), 64'd15);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("stall_rst", 64'(stall_cnt), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
Parametrised pipeline register stage that generalises the plain 32-bit clocked register. Adds:
- configurable width and reset value
- valid/ready handshake with a 2-entry skid buffer, so in_ready is a registered output
- synchronous flush
- occupancy status

It sits between datapath stages, for example between the fetch/decode/execute register boundaries of the CPU. It sustains one transfer per cycle with back-pressure.

Parameters:
- WIDTH, 32, data width in bits (>=1)
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into both data registers on reset
- STALL_CNT_W, 16, width of the stall counter (used only with PIPE_REG_STALL_CNT_EN)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous active-high reset
- flush  input  1  synchronous discard of all held entries
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  stage can accept; registered (equals !skid_valid)
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  payload of the oldest entry (main register)
- occupancy  output  2  entries held: 0, 1 or 2
- stall_cnt  output  STALL_CNT_W  saturating stall counter; present only with PIPE_REG_STALL_CNT_EN

Behaviour:
- Storage: main register (main_valid, main_data) and skid register (skid_valid, skid_data). out_valid=main_valid, out_data=main_data, in_ready=!skid_valid, occupancy=main_valid+skid_valid.
- Transfers: input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
- Priority: reset > flush > normal operation.
- Reset (sampled at clk edge): main_valid=0, skid_valid=0, main_data=skid_data=RESET_VALUE. After the reset edge: in_ready=1, out_valid=0, occupancy=0.
- Flush: next state has main_valid=0 and skid_valid=0; data registers hold their values.
  - Any input transfer in the flush cycle is dropped.
  - Any output transfer in the flush cycle still counts as consumed downstream.
  - After a flush, in_ready=1.
- State machine (EMPTY/HALF/FULL = occupancy 0/1/2):
  - EMPTY: input transfer -> main<=in_data, go to HALF; otherwise stay EMPTY.
  - HALF, input and output transfer -> main<=in_data, stay HALF (full throughput).
  - HALF, input transfer only -> skid<=in_data, go to FULL; in_ready drops next cycle.
  - HALF, output transfer only -> EMPTY.
  - HALF, neither -> hold.
  - FULL: in_ready=0, so no input transfer. Output transfer -> main<=skid_data, skid_valid=0, go to HALF. Otherwise hold.
- Latency: 1 cycle from input transfer to out_valid when empty. Steady-state throughput 1 transfer/cycle.
- Order: strictly FIFO; no entry is lost or duplicated.
- Stability: out_data and out_valid are stable while out_valid && !out_ready.
- Combinational paths: none from out_ready or in_valid to in_ready or out_*.
- Unaccepted cycles: in_data is ignored when in_valid=0 or in_ready=0.

Optional Feature:
- Macro: PIPE_REG_STALL_CNT_EN.
- Defined:
  - port stall_cnt exists.
  - Increments by 1 on each cycle with out_valid && !out_ready.
  - Saturates at all-ones.
  - Cleared to 0 by reset; unaffected by flush.
- Undefined: port and counter logic absent; all other behaviour identical.

Test Plan:
1. Reset with in_valid=1, in_data=32'hDEAD_BEEF -> next cycle out_valid=0, occupancy=0, in_ready=1, out_data=0.
2. Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, out_valid continuously 1, occupancy stays 1.
3. Back-pressure: push 5 then 6 with out_ready=0 -> occupancy 2, in_ready=0, out_data=5. Raise out_ready -> outputs 5 then 6, in_ready returns to 1 one cycle after 5 is consumed.
4. Flush while FULL (entries 7,8) with in_valid=1, in_data=9 -> next cycle occupancy=0, out_valid=0, in_ready=1; 9 never appears on the output.
5. Reset asserted while FULL -> next cycle occupancy=0, out_data=RESET_VALUE. With PIPE_REG_STALL_CNT_EN and STALL_CNT_W=4: 20 stalled cycles -> stall_cnt=15; a subsequent flush leaves it at 15, reset clears it to 0.
